// File: rtl/nettlp_rx_parser.sv
// NetTLP receive decapsulator: filters Ethernet/IPv4/UDP/NetTLP frames from the MAC,
// strips the 48-byte encapsulation and forwards the TLP in PCIe DWORD byte order.
module nettlp_rx_parser #(
    parameter logic [15:0] UDP_PORT_BASE = 16'h3000,
    parameter bit          CHECK_IP      = 1'b1
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic [31:0] local_ip,
    input  logic        s_axis_rx_tvalid,
    input  logic        s_axis_rx_tlast,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic        s_axis_rx_tuser,
    output logic        m_axis_tlp_tvalid,
    output logic        m_axis_tlp_tlast,
    output logic [7:0]  m_axis_tlp_tkeep,
    output logic [63:0] m_axis_tlp_tdata,
    output logic        m_axis_tlp_tuser,
    output logic        tlp_hdr_valid,
    output logic [15:0] tlp_seq,
    output logic [31:0] tlp_tstamp,
    output logic [31:0] cnt_rx_ok,
    output logic [31:0] cnt_drop,
    output logic [31:0] cnt_err
);

    localparam int unsigned BEAT_W = 3;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam logic [BEAT_W-1:0] LAST_HDR_BEAT = BEAT_W'(5);
    localparam logic [7:0] PORT_HI  = UDP_PORT_BASE[15:8];
    localparam logic [3:0] PORT_MID = UDP_PORT_BASE[7:4];

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                mismatch_q, mismatch_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tuser_q, tuser_d;
    logic                hdr_valid_q, hdr_valid_d;
    logic [15:0]         seq_q, seq_d;
    logic [31:0]         tstamp_q, tstamp_d;
    logic [CNT_W-1:0]    cnt_rx_ok_q, cnt_rx_ok_d;
    logic [CNT_W-1:0]    cnt_drop_q, cnt_drop_d;
    logic [CNT_W-1:0]    cnt_err_q, cnt_err_d;

    logic [7:0]          rx_b [8];
    logic [BEAT_W-1:0]   hdr_idx;
    logic                beat_mismatch;

    // Wire byte n of a beat sits in lane n; the TLP wants the first wire byte of each DWORD in its MSB.
    function automatic logic [DATA_W-1:0] swap_data(input logic [DATA_W-1:0] d);
        return {d[39:32], d[47:40], d[55:48], d[63:56],
                d[7:0],   d[15:8],  d[23:16], d[31:24]};
    endfunction

    function automatic logic [KEEP_W-1:0] swap_keep(input logic [KEEP_W-1:0] k);
        return {k[4], k[5], k[6], k[7], k[0], k[1], k[2], k[3]};
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rx_b[i] = s_axis_rx_tdata[8*i +: 8];
        end
    end

    // Per-beat header field checks; an IDLE beat is header beat 0.
    always_comb begin
        hdr_idx       = (state_q == ST_IDLE) ? '0 : beat_q;
        beat_mismatch = 1'b0;
        case (hdr_idx)
            3'd1: beat_mismatch = ({rx_b[4], rx_b[5]} != 16'h0800) || (rx_b[6] != 8'h45);
            3'd2: beat_mismatch = (rx_b[7] != 8'h11);
            3'd3: beat_mismatch = CHECK_IP && ({rx_b[6], rx_b[7]} != local_ip[31:16]);
            3'd4: beat_mismatch = (CHECK_IP && ({rx_b[0], rx_b[1]} != local_ip[15:0]))
                               || (rx_b[4] != PORT_HI) || (rx_b[5][7:4] != PORT_MID);
            default: beat_mismatch = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        mismatch_d  = mismatch_q;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        tkeep_d     = tkeep_q;
        tdata_d     = tdata_q;
        hdr_valid_d = 1'b0;
        seq_d       = seq_q;
        tstamp_d    = tstamp_q;
        cnt_rx_ok_d = cnt_rx_ok_q;
        cnt_drop_d  = cnt_drop_q;
        cnt_err_d   = cnt_err_q;

        unique case (state_q)
            ST_SYNC: begin
                if (!s_axis_rx_tvalid || s_axis_rx_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_HDR: begin
                if (s_axis_rx_tvalid) begin
                    if (s_axis_rx_tlast) begin
                        cnt_drop_d = cnt_drop_q + CNT_W'(1);
                        state_d    = ST_IDLE;
                    end else if (hdr_idx == LAST_HDR_BEAT) begin
                        if (mismatch_q || beat_mismatch) begin
                            state_d = ST_DROP;
                        end else begin
                            state_d     = ST_PAYLOAD;
                            hdr_valid_d = 1'b1;
                            seq_d       = {rx_b[2], rx_b[3]};
                            tstamp_d    = {rx_b[4], rx_b[5], rx_b[6], rx_b[7]};
                        end
                    end else begin
                        state_d    = ST_HDR;
                        beat_d     = hdr_idx + BEAT_W'(1);
                        mismatch_d = ((state_q == ST_HDR) && mismatch_q) || beat_mismatch;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (s_axis_rx_tvalid) begin
                    tvalid_d = 1'b1;
                    tdata_d  = swap_data(s_axis_rx_tdata);
                    tkeep_d  = swap_keep(s_axis_rx_tkeep);
                    tlast_d  = s_axis_rx_tlast;
                    if (s_axis_rx_tlast) begin
                        tuser_d = s_axis_rx_tuser;
                        state_d = ST_IDLE;
                        if (s_axis_rx_tuser) begin
                            cnt_err_d = cnt_err_q + CNT_W'(1);
                        end else begin
                            cnt_rx_ok_d = cnt_rx_ok_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
                    cnt_drop_d = cnt_drop_q + CNT_W'(1);
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_SYNC;
            beat_q      <= '0;
            mismatch_q  <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
            tdata_q     <= '0;
            tuser_q     <= 1'b0;
            hdr_valid_q <= 1'b0;
            seq_q       <= '0;
            tstamp_q    <= '0;
            cnt_rx_ok_q <= '0;
            cnt_drop_q  <= '0;
            cnt_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            mismatch_q  <= mismatch_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tkeep_q     <= tkeep_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            hdr_valid_q <= hdr_valid_d;
            seq_q       <= seq_d;
            tstamp_q    <= tstamp_d;
            cnt_rx_ok_q <= cnt_rx_ok_d;
            cnt_drop_q  <= cnt_drop_d;
            cnt_err_q   <= cnt_err_d;
        end
    end

    assign m_axis_tlp_tvalid = tvalid_q;
    assign m_axis_tlp_tlast  = tlast_q;
    assign m_axis_tlp_tkeep  = tkeep_q;
    assign m_axis_tlp_tdata  = tdata_q;
    assign m_axis_tlp_tuser  = tuser_q;
    assign tlp_hdr_valid     = hdr_valid_q;
    assign tlp_seq           = seq_q;
    assign tlp_tstamp        = tstamp_q;
    assign cnt_rx_ok         = cnt_rx_ok_q;
    assign cnt_drop          = cnt_drop_q;
    assign cnt_err           = cnt_err_q;

endmodule

// File: tb/tb_nettlp_rx_parser.sv
// Bench for nettlp_rx_parser: frames are built as byte arrays, a frame-level model
// predicts TLP beats, header sideband and counters, and a per-cycle compare checks them.
`timescale 1ns/1ps
module tb_nettlp_rx_parser;

    localparam logic [31:0] LOCAL_IP = 32'h0A000001;

    logic        clk156 = 1'b0;
    logic        sys_rst_n;
    logic [31:0] local_ip;
    logic        s_axis_rx_tvalid, s_axis_rx_tlast, s_axis_rx_tuser;
    logic [7:0]  s_axis_rx_tkeep;
    logic [63:0] s_axis_rx_tdata;
    logic        m_axis_tlp_tvalid, m_axis_tlp_tlast, m_axis_tlp_tuser;
    logic [7:0]  m_axis_tlp_tkeep;
    logic [63:0] m_axis_tlp_tdata;
    logic        tlp_hdr_valid;
    logic [15:0] tlp_seq;
    logic [31:0] tlp_tstamp;
    logic [31:0] cnt_rx_ok, cnt_drop, cnt_err;

    nettlp_rx_parser dut (
        .clk156            (clk156),
        .sys_rst_n         (sys_rst_n),
        .local_ip          (local_ip),
        .s_axis_rx_tvalid  (s_axis_rx_tvalid),
        .s_axis_rx_tlast   (s_axis_rx_tlast),
        .s_axis_rx_tkeep   (s_axis_rx_tkeep),
        .s_axis_rx_tdata   (s_axis_rx_tdata),
        .s_axis_rx_tuser   (s_axis_rx_tuser),
        .m_axis_tlp_tvalid (m_axis_tlp_tvalid),
        .m_axis_tlp_tlast  (m_axis_tlp_tlast),
        .m_axis_tlp_tkeep  (m_axis_tlp_tkeep),
        .m_axis_tlp_tdata  (m_axis_tlp_tdata),
        .m_axis_tlp_tuser  (m_axis_tlp_tuser),
        .tlp_hdr_valid     (tlp_hdr_valid),
        .tlp_seq           (tlp_seq),
        .tlp_tstamp        (tlp_tstamp),
        .cnt_rx_ok         (cnt_rx_ok),
        .cnt_drop          (cnt_drop),
        .cnt_err           (cnt_err)
    );

    always #5 clk156 = ~clk156;

    typedef struct {
        int unsigned cyc;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        int unsigned cyc;
        logic [15:0] seq;
        logic [31:0] ts;
    } hdr_t;

    beat_t       exp_q[$];
    hdr_t        hdr_q[$];
    beat_t       act_log[$];
    beat_t       a_beat, e_beat;
    hdr_t        e_hdr;
    logic [7:0]  frm[$];
    logic [7:0]  tlp[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_ok, m_drop, m_err, m_ts;
    logic [15:0] m_seq;

    always @(posedge clk156) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk156) begin
        if (sys_rst_n) begin
            if (m_axis_tlp_tvalid) begin
                a_beat.cyc  = cyc;
                a_beat.data = m_axis_tlp_tdata;
                a_beat.keep = m_axis_tlp_tkeep;
                a_beat.last = m_axis_tlp_tlast;
                a_beat.user = m_axis_tlp_tuser;
                act_log.push_back(a_beat);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_tvalid", 64'(m_axis_tlp_tvalid), 64'd0);
                end else begin
                    e_beat = exp_q.pop_front();
                    chk("beat_cycle", 64'(cyc), 64'(e_beat.cyc));
                    chk("beat_tdata", m_axis_tlp_tdata, e_beat.data);
                    chk("beat_tkeep", 64'(m_axis_tlp_tkeep), 64'(e_beat.keep));
                    chk("beat_tlast", 64'(m_axis_tlp_tlast), 64'(e_beat.last));
                    if (e_beat.last) chk("beat_tuser", 64'(m_axis_tlp_tuser), 64'(e_beat.user));
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e_beat = exp_q.pop_front();
                chk("missing_beat_cycle", 64'(cyc), 64'(e_beat.cyc));
            end
            if (tlp_hdr_valid) begin
                if (hdr_q.size() == 0) begin
                    chk("unexpected_hdr_valid", 64'(tlp_hdr_valid), 64'd0);
                end else begin
                    e_hdr = hdr_q.pop_front();
                    chk("hdr_cycle", 64'(cyc), 64'(e_hdr.cyc));
                    chk("hdr_seq", 64'(tlp_seq), 64'(e_hdr.seq));
                    chk("hdr_tstamp", 64'(tlp_tstamp), 64'(e_hdr.ts));
                end
            end
            if (hdr_q.size() > 0 && hdr_q[0].cyc < cyc) begin
                e_hdr = hdr_q.pop_front();
                chk("missing_hdr_cycle", 64'(cyc), 64'(e_hdr.cyc));
            end
            chk("cnt_rx_ok", 64'(cnt_rx_ok), 64'(m_ok));
            chk("cnt_drop", 64'(cnt_drop), 64'(m_drop));
            chk("cnt_err", 64'(cnt_err), 64'(m_err));
            chk("tlp_seq", 64'(tlp_seq), 64'(m_seq));
            chk("tlp_tstamp", 64'(tlp_tstamp), 64'(m_ts));
        end
    end

    // Load the first n bytes of v (MSB first) as the TLP payload.
    task automatic set_tlp(input logic [127:0] v, input int n);
        tlp.delete();
        for (int i = 0; i < n; i++) tlp.push_back(v[8*(15-i) +: 8]);
    endtask

    task automatic fill_tlp(input int n, input logic [7:0] seed);
        tlp.delete();
        for (int i = 0; i < n; i++) tlp.push_back(seed + 8'(i));
    endtask

    task automatic build_frame(input logic [31:0] dip, input logic [15:0] dport,
                               input logic [15:0] seq, input logic [31:0] ts);
        frm.delete();
        for (int i = 0; i < 48; i++) frm.push_back(8'h00);
        for (int i = 0; i < 6; i++) begin
            frm[i]   = 8'h02;
            frm[6+i] = 8'h04 + 8'(i);
        end
        frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45;
        frm[22] = 8'h40; frm[23] = 8'h11;
        frm[26] = 8'h0A; frm[29] = 8'h09;
        frm[30] = dip[31:24]; frm[31] = dip[23:16]; frm[32] = dip[15:8]; frm[33] = dip[7:0];
        frm[34] = 8'h30; frm[35] = 8'h00;
        frm[36] = dport[15:8]; frm[37] = dport[7:0];
        frm[42] = seq[15:8]; frm[43] = seq[7:0];
        frm[44] = ts[31:24]; frm[45] = ts[23:16]; frm[46] = ts[15:8]; frm[47] = ts[7:0];
        foreach (tlp[i]) frm.push_back(tlp[i]);
    endtask

    // Frame acceptance straight from the field rules on the byte array.
    function automatic bit frame_ok();
        logic [15:0] port;
        if (frm.size() <= 48) return 1'b0;
        if ({frm[12], frm[13]} != 16'h0800 || frm[14] != 8'h45 || frm[23] != 8'h11) return 1'b0;
        if ({frm[30], frm[31], frm[32], frm[33]} != LOCAL_IP) return 1'b0;
        port = {frm[36], frm[37]};
        if (port[15:4] != 12'h300) return 1'b0;
        return 1'b1;
    endfunction

    // Output beat j viewed as two PCIe DWORDs: the first wire byte of each DWORD is its MSB.
    function automatic beat_t tlp_beat(input int j);
        beat_t b;
        int    idx;
        b.cyc  = 0;
        b.data = '0;
        b.keep = '0;
        b.last = 1'b0;
        b.user = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 4; m++) begin
                idx = 8*j + 4*d + m;
                if (idx < frm.size()) begin
                    b.data[32*d + 8*(3-m) +: 8] = frm[idx];
                    b.keep[4*d + 3 - m]         = 1'b1;
                end
            end
        end
        return b;
    endfunction

    task automatic send_frame(input bit fcs_err, input bit gap, input int rst_at);
        int          n, nb;
        bit          acc, discard;
        logic [63:0] d;
        logic [7:0]  k;
        beat_t       eb;
        hdr_t        hb;
        n       = frm.size();
        nb      = (n + 7) / 8;
        acc     = frame_ok();
        discard = 1'b0;
        for (int j = 0; j < nb; j++) begin
            @(negedge clk156);
            d = '0;
            k = '0;
            for (int l = 0; l < 8; l++) begin
                if (8*j + l < n) begin
                    d[8*l +: 8] = frm[8*j + l];
                    k[l]        = 1'b1;
                end
            end
            s_axis_rx_tvalid = 1'b1;
            s_axis_rx_tdata  = d;
            s_axis_rx_tkeep  = k;
            s_axis_rx_tlast  = (j == nb - 1);
            s_axis_rx_tuser  = (j == nb - 1) && fcs_err;
            if (!discard && acc && j >= 6) begin
                eb      = tlp_beat(j);
                eb.cyc  = cyc + 1;
                eb.last = (j == nb - 1);
                eb.user = (j == nb - 1) && fcs_err;
                exp_q.push_back(eb);
            end
            if (!discard && acc && j == 5) begin
                hb.cyc = cyc + 1;
                hb.seq = {frm[42], frm[43]};
                hb.ts  = {frm[44], frm[45], frm[46], frm[47]};
                hdr_q.push_back(hb);
                #1;
                m_seq = hb.seq;
                m_ts  = hb.ts;
            end
            if (!discard && j == nb - 1) begin
                #1;
                if (!acc) m_drop++;
                else if (fcs_err) m_err++;
                else m_ok++;
            end
            if (j == rst_at) begin
                @(posedge clk156);
                #2;
                sys_rst_n = 1'b0;
                discard   = 1'b1;
                m_ok = '0; m_drop = '0; m_err = '0; m_seq = '0; m_ts = '0;
                exp_q.delete();
                hdr_q.delete();
            end
            if (rst_at >= 0 && j == rst_at + 1) begin
                @(posedge clk156);
                #2;
                sys_rst_n = 1'b1;
            end
        end
        if (gap) begin
            @(negedge clk156);
            s_axis_rx_tvalid = 1'b0;
            s_axis_rx_tlast  = 1'b0;
            s_axis_rx_tuser  = 1'b0;
            s_axis_rx_tkeep  = '0;
            s_axis_rx_tdata  = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk156);
    endtask

    initial begin
        sys_rst_n        = 1'b0;
        local_ip         = LOCAL_IP;
        s_axis_rx_tvalid = 1'b0;
        s_axis_rx_tlast  = 1'b0;
        s_axis_rx_tuser  = 1'b0;
        s_axis_rx_tkeep  = '0;
        s_axis_rx_tdata  = '0;
        m_ok = '0; m_drop = '0; m_err = '0; m_seq = '0; m_ts = '0;
        idle(3);
        chk("rst_tvalid", 64'(m_axis_tlp_tvalid), 64'd0);
        chk("rst_hdr_valid", 64'(tlp_hdr_valid), 64'd0);
        chk("rst_cnt_rx_ok", 64'(cnt_rx_ok), 64'd0);
        chk("rst_cnt_drop", 64'(cnt_drop), 64'd0);
        chk("rst_tlp_seq", 64'(tlp_seq), 64'd0);
        @(posedge clk156);
        #2 sys_rst_n = 1'b1;
        idle(3);

        // Valid 3DW MWr with one data DWORD
        set_tlp(128'h40000001_0100000F_F0000000_DEADBEEF, 16);
        build_frame(LOCAL_IP, 16'h3005, 16'h0102, 32'hA1B2C3D4);
        send_frame(1'b0, 1'b1, -1);
        idle(4);
        chk("t1_nbeats", 64'(act_log.size()), 64'd2);
        chk("t1_beat0_data", act_log[0].data, 64'h0100000F_40000001);
        chk("t1_beat1_data", act_log[1].data, 64'hDEADBEEF_F0000000);
        chk("t1_beat1_keep", 64'(act_log[1].keep), 64'hFF);
        chk("t1_seq", 64'(tlp_seq), 64'h0102);
        chk("t1_tstamp", 64'(tlp_tstamp), 64'hA1B2C3D4);
        chk("t1_cnt_rx_ok", 64'(cnt_rx_ok), 64'd1);

        // Wrong UDP port, then wrong destination IP
        build_frame(LOCAL_IP, 16'h4000, 16'h0103, 32'h11111111);
        send_frame(1'b0, 1'b1, -1);
        build_frame(32'h0A000002, 16'h3005, 16'h0104, 32'h22222222);
        send_frame(1'b0, 1'b1, -1);
        idle(4);
        chk("t2_cnt_drop", 64'(cnt_drop), 64'd2);
        chk("t2_nbeats", 64'(act_log.size()), 64'd2);

        // Bad FCS on an accepted frame
        build_frame(LOCAL_IP, 16'h3001, 16'h0200, 32'h33333333);
        send_frame(1'b1, 1'b1, -1);
        idle(4);
        chk("t3_cnt_err", 64'(cnt_err), 64'd1);
        chk("t3_cnt_rx_ok", 64'(cnt_rx_ok), 64'd1);
        chk("t3_last_tuser", 64'(act_log[act_log.size()-1].user), 64'd1);

        // 40-byte runt immediately followed by a valid frame
        build_frame(LOCAL_IP, 16'h3005, 16'h0AAA, 32'h44444444);
        while (frm.size() > 40) void'(frm.pop_back());
        send_frame(1'b0, 1'b0, -1);
        build_frame(LOCAL_IP, 16'h300F, 16'h0BBB, 32'h55555555);
        send_frame(1'b0, 1'b1, -1);
        idle(4);
        chk("t4_cnt_drop", 64'(cnt_drop), 64'd3);
        chk("t4_cnt_rx_ok", 64'(cnt_rx_ok), 64'd2);
        chk("t4_seq", 64'(tlp_seq), 64'h0BBB);

        // Reset lands mid-payload; the tail is discarded, the next frame is taken
        fill_tlp(48, 8'h10);
        build_frame(LOCAL_IP, 16'h3005, 16'h0CCC, 32'h66666666);
        send_frame(1'b0, 1'b1, 8);
        idle(3);
        set_tlp(128'h40000001_0100000F_F0000000_DEADBEEF, 16);
        build_frame(LOCAL_IP, 16'h3005, 16'h0DDD, 32'h77777777);
        send_frame(1'b0, 1'b1, -1);
        idle(4);
        chk("t5_cnt_rx_ok", 64'(cnt_rx_ok), 64'd1);
        chk("t5_cnt_drop", 64'(cnt_drop), 64'd0);
        chk("t5_seq", 64'(tlp_seq), 64'h0DDD);

        // Final beat with four valid bytes
        set_tlp(128'h00010203_04050607_11223344_00000000, 12);
        build_frame(LOCAL_IP, 16'h3005, 16'h0EEE, 32'h88888888);
        send_frame(1'b0, 1'b1, -1);
        idle(4);
        chk("t6_last_keep", 64'(act_log[act_log.size()-1].keep), 64'h0F);
        chk("t6_last_data", act_log[act_log.size()-1].data, 64'h00000000_11223344);

        // 32 back-to-back frames of varying length
        for (int i = 0; i < 32; i++) begin
            fill_tlp(4 + 4*(i % 4) + (i % 3), 8'(i * 7));
            build_frame(LOCAL_IP, 16'h3000 + 16'(i % 16), 16'(i), 32'h01010101 * 32'(i));
            send_frame(1'b0, i == 31, -1);
        end
        idle(5);
        chk("t7_cnt_rx_ok", 64'(cnt_rx_ok), 64'd34);
        chk("t7_seq", 64'(tlp_seq), 64'd31);
        chk("end_beats_pending", 64'(exp_q.size()), 64'd0);
        chk("end_hdrs_pending", 64'(hdr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
